// File: rtl/merge_n_sync.sv
// -----------------------------------------------------------------------------
// merge_n_sync
//   Merges N_CH upstream 4-phase req/ack channels onto one downstream req/ack
//   pair. The upstream channel to serve is chosen by decoding the opcode class
//   while idle; the grant then holds for a full 4-phase handshake
//   (IDLE -> REQ -> ACK -> REL -> IDLE). All outputs are registered.
//
//   Optional feature macro: MERGE_N_SYNC_TIMEOUT_EN
//     When defined, a watchdog aborts a handshake stuck in REQ or REL for
//     TO_CYCLES cycles and raises a sticky timeout flag. When undefined, no
//     counter is built and timeout is constant 0.
//
// Ports
//   clk         clock, rising edge
//   rst_n       synchronous active-low reset
//   opcode      7-bit instruction opcode, sampled only in IDLE
//   req_in      per-channel upstream request (N_CH bits)
//   ack_in      downstream acknowledge
//   req_out     downstream request (registered)
//   ack_out     per-channel upstream acknowledge, one-hot or zero (registered)
//   grant_idx   index of the granted channel, 0 when idle
//   busy        high in every state except IDLE
//   illegal_op  high in the cycle after an IDLE edge with an illegal opcode
//               and any request pending
//   timeout     sticky watchdog flag
// -----------------------------------------------------------------------------
module merge_n_sync #(
   parameter int N_CH      = 3,
   parameter int CH_BJ     = 0,
   parameter int CH_S      = 1,
   parameter int CH_ALU    = 2,
   parameter int TO_CYCLES = 255,
   localparam int GW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [6:0]      opcode,
   input  logic [N_CH-1:0] req_in,
   input  logic            ack_in,
   output logic            req_out,
   output logic [N_CH-1:0] ack_out,
   output logic [GW-1:0]   grant_idx,
   output logic            busy,
   output logic            illegal_op,
   output logic            timeout
);

   // Elaboration-time parameter sanity checks.
   if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
      $error("merge_n_sync: N_CH must be in 1..16");
   end
   if (TO_CYCLES < 1) begin : g_bad_to
      $error("merge_n_sync: TO_CYCLES must be at least 1");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      ACK  = 2'd2,
      REL  = 2'd3
   } state_t;

   state_t            st_q, st_d;
   logic              req_q;
   logic [N_CH-1:0]   ack_q;
   logic [GW-1:0]     grant_q;
   logic              busy_q;
   logic              illegal_q;

   // Opcode class -> channel index; -1 for opcodes outside every class.
   function automatic int decode_ch(input logic [6:0] op);
      int ch;
      case (op)
         7'b1100011, 7'b1101111:                       ch = CH_BJ;
         7'b0100011:                                   ch = CH_S;
         7'b0110011, 7'b0010011, 7'b0000011, 7'b0000000: ch = CH_ALU;
         default:                                      ch = -1;
      endcase
      return ch;
   endfunction

   int              tgt_ch;
   logic            op_legal;
   logic [N_CH-1:0] tgt_mask;
   logic [N_CH-1:0] grant_mask;
   logic            tgt_req;
   logic            grant_req;
   logic            abort;

   always_comb begin
      tgt_ch   = decode_ch(opcode);
      // A class mapped onto a channel that does not exist is illegal too.
      op_legal = (tgt_ch >= 0) && (tgt_ch < N_CH);
      for (int i = 0; i < N_CH; i++) begin
         tgt_mask[i]   = op_legal && (tgt_ch == i);
         grant_mask[i] = (grant_q == GW'(i));
      end
      tgt_req   = |(req_in & tgt_mask);
      grant_req = |(req_in & grant_mask);
   end

`ifdef MERGE_N_SYNC_TIMEOUT_EN
   localparam int CW = $clog2(TO_CYCLES + 1);
   logic [CW-1:0] cnt_q;
   logic          timeout_q;
   logic          to_hit;

   assign to_hit = ((st_q == REQ) || (st_q == REL)) && (cnt_q == CW'(TO_CYCLES - 1));
`else
   logic          to_hit;
   assign to_hit = 1'b0;
`endif

   // Next-state decode. A normal handshake step wins over a watchdog abort
   // taken at the same edge.
   always_comb begin
      st_d  = st_q;
      abort = 1'b0;
      case (st_q)
         IDLE: if (tgt_req) st_d = REQ;
         REQ: begin
            if (ack_in) st_d = ACK;
            else if (to_hit) begin
               st_d  = IDLE;
               abort = 1'b1;
            end
         end
         // An early upstream drop during REQ is simply seen here at once.
         ACK: if (!grant_req) st_d = REL;
         REL: begin
            if (!ack_in) st_d = IDLE;
            else if (to_hit) begin
               st_d  = IDLE;
               abort = 1'b1;
            end
         end
         default: st_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st_q      <= IDLE;
         req_q     <= 1'b0;
         ack_q     <= '0;
         grant_q   <= '0;
         busy_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         st_q      <= st_d;
         busy_q    <= (st_d != IDLE);
         illegal_q <= (st_q == IDLE) && !op_legal && (|req_in);
         case (st_q)
            IDLE: begin
               if (st_d == REQ) begin
                  req_q   <= 1'b1;
                  grant_q <= GW'(tgt_ch);
               end
            end
            REQ: begin
               if (st_d == ACK) begin
                  ack_q <= grant_mask;
               end else if (abort) begin
                  req_q   <= 1'b0;
                  ack_q   <= '0;
                  grant_q <= '0;
               end
            end
            ACK: begin
               if (st_d == REL) req_q <= 1'b0;
            end
            REL: begin
               if (st_d == IDLE) begin
                  req_q   <= 1'b0;
                  ack_q   <= '0;
                  grant_q <= '0;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef MERGE_N_SYNC_TIMEOUT_EN
   // Watchdog: clears on every state change, counts cycles spent in REQ/REL.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (st_d != st_q) cnt_q <= '0;
         else if ((st_q == REQ) || (st_q == REL)) cnt_q <= cnt_q + 1'b1;
         if (abort) timeout_q <= 1'b1;
      end
   end
   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   assign req_out    = req_q;
   assign ack_out    = ack_q;
   assign grant_idx  = grant_q;
   assign busy       = busy_q;
   assign illegal_op = illegal_q;

endmodule

// File: tb/tb_merge_n_sync.sv
module tb_merge_n_sync;

   localparam int N_CH = 3;
   localparam int GW   = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [6:0]      opcode;
   logic [N_CH-1:0] req_in;
   logic            ack_in;
   logic            req_out;
   logic [N_CH-1:0] ack_out;
   logic [GW-1:0]   grant_idx;
   logic            busy;
   logic            illegal_op;
   logic            timeout;

   int n_total = 0;
   int n_bad   = 0;
   logic exp_to = 1'b0;

   always #5 clk = ~clk;

   merge_n_sync #(
      .N_CH(N_CH), .CH_BJ(0), .CH_S(1), .CH_ALU(2), .TO_CYCLES(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .req_in(req_in),
      .ack_in(ack_in), .req_out(req_out), .ack_out(ack_out),
      .grant_idx(grant_idx), .busy(busy), .illegal_op(illegal_op),
      .timeout(timeout)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance one edge, then settle so outputs are sampled away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic r, input logic [2:0] a,
                            input logic [1:0] g, input logic b, input logic il);
      check({tag, ".req_out"}, 32'(req_out), 32'(r));
      check({tag, ".ack_out"}, 32'(ack_out), 32'(a));
      check({tag, ".grant"},   32'(grant_idx), 32'(g));
      check({tag, ".busy"},    32'(busy), 32'(b));
      check({tag, ".illegal"}, 32'(illegal_op), 32'(il));
      check({tag, ".timeout"}, 32'(timeout), 32'(exp_to));
   endtask

   initial begin
      rst_n  = 1'b0;
      opcode = 7'b0100011;
      req_in = 3'b111;
      ack_in = 1'b1;

      // Reset with everything asserted upstream and downstream.
      repeat (3) tick();
      check_all("rst", 1'b0, 3'b000, 2'd0, 1'b0, 1'b0);
      rst_n  = 1'b1;
      req_in = 3'b000;
      ack_in = 1'b0;
      tick();
      check_all("idle", 1'b0, 3'b000, 2'd0, 1'b0, 1'b0);

      // Store handshake on channel 1.
      opcode = 7'b0100011;
      req_in = 3'b010;
      tick();
      check_all("st.req", 1'b1, 3'b000, 2'd1, 1'b1, 1'b0);
      ack_in = 1'b1;
      tick();
      check_all("st.ack", 1'b1, 3'b010, 2'd1, 1'b1, 1'b0);
      req_in = 3'b000;
      tick();
      check_all("st.rel", 1'b0, 3'b010, 2'd1, 1'b1, 1'b0);
      ack_in = 1'b0;
      tick();
      check_all("st.done", 1'b0, 3'b000, 2'd0, 1'b0, 1'b0);

      // Steering: jump opcode targets channel 0, only channel 2 requests.
      opcode = 7'b1101111;
      req_in = 3'b100;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("steer.req_out", 32'(req_out), 32'd0);
         check("steer.ack_out", 32'(ack_out), 32'd0);
      end
      check("steer.illegal", 32'(illegal_op), 32'd0);
      opcode = 7'b0110011;
      tick();
      check_all("alu.req", 1'b1, 3'b000, 2'd2, 1'b1, 1'b0);
      opcode = 7'b0100011;           // changing opcode while busy is ignored
      ack_in = 1'b1;
      tick();
      check_all("alu.ack", 1'b1, 3'b100, 2'd2, 1'b1, 1'b0);
      req_in = 3'b000;
      tick();
      check_all("alu.rel", 1'b0, 3'b100, 2'd2, 1'b1, 1'b0);
      ack_in = 1'b0;
      tick();
      check_all("alu.done", 1'b0, 3'b000, 2'd0, 1'b0, 1'b0);

      // Illegal opcode with a pending request.
      opcode = 7'b1111111;
      req_in = 3'b001;
      tick();
      check_all("ill.on", 1'b0, 3'b000, 2'd0, 1'b0, 1'b1);
      tick();
      check_all("ill.hold", 1'b0, 3'b000, 2'd0, 1'b0, 1'b1);
      req_in = 3'b000;
      tick();
      check_all("ill.off", 1'b0, 3'b000, 2'd0, 1'b0, 1'b0);

      // Load on channel 2 with an early upstream drop while in REQ.
      opcode = 7'b0000011;
      req_in = 3'b100;
      tick();
      check_all("early.req", 1'b1, 3'b000, 2'd2, 1'b1, 1'b0);
      req_in = 3'b000;
      tick();
      check_all("early.wait", 1'b1, 3'b000, 2'd2, 1'b1, 1'b0);
      ack_in = 1'b1;
      tick();
      check_all("early.ack", 1'b1, 3'b100, 2'd2, 1'b1, 1'b0);
      tick();
      check_all("early.rel", 1'b0, 3'b100, 2'd2, 1'b1, 1'b0);
      ack_in = 1'b0;
      tick();
      check_all("early.done", 1'b0, 3'b000, 2'd0, 1'b0, 1'b0);

      // Reset in the middle of a branch handshake on channel 0.
      opcode = 7'b1100011;
      req_in = 3'b001;
      tick();
      check_all("mid.req", 1'b1, 3'b000, 2'd0, 1'b1, 1'b0);
      ack_in = 1'b1;
      tick();
      check_all("mid.ack", 1'b1, 3'b001, 2'd0, 1'b1, 1'b0);
      rst_n = 1'b0;
      tick();
      check_all("mid.rst", 1'b0, 3'b000, 2'd0, 1'b0, 1'b0);
      rst_n  = 1'b1;
      req_in = 3'b000;
      ack_in = 1'b0;
      tick();
      check_all("mid.idle", 1'b0, 3'b000, 2'd0, 1'b0, 1'b0);
      req_in = 3'b001;
      tick();
      check_all("mid.regrant", 1'b1, 3'b000, 2'd0, 1'b1, 1'b0);

`ifdef MERGE_N_SYNC_TIMEOUT_EN
      // Channel 0 granted, ack never arrives: abort after 8 cycles in REQ.
      for (int i = 1; i < 8; i++) begin
         tick();
         check("to.wait.req_out", 32'(req_out), 32'd1);
         check("to.wait.ack_out", 32'(ack_out), 32'd0);
      end
      req_in = 3'b000;
      tick();
      exp_to = 1'b1;
      check_all("to.abort", 1'b0, 3'b000, 2'd0, 1'b0, 1'b0);
`else
      // Without the watchdog, REQ waits indefinitely.
      for (int i = 0; i < 12; i++) tick();
      check_all("nowd.wait", 1'b1, 3'b000, 2'd0, 1'b1, 1'b0);
      req_in = 3'b000;
      ack_in = 1'b1;
      tick();
      check_all("nowd.ack", 1'b1, 3'b001, 2'd0, 1'b1, 1'b0);
      tick();
      check_all("nowd.rel", 1'b0, 3'b001, 2'd0, 1'b1, 1'b0);
      ack_in = 1'b0;
      tick();
      check_all("nowd.done", 1'b0, 3'b000, 2'd0, 1'b0, 1'b0);
`endif

      // A clean store handshake afterwards; timeout (if set) must stick.
      opcode = 7'b0100011;
      req_in = 3'b010;
      tick();
      check_all("post.req", 1'b1, 3'b000, 2'd1, 1'b1, 1'b0);
      ack_in = 1'b1;
      tick();
      check_all("post.ack", 1'b1, 3'b010, 2'd1, 1'b1, 1'b0);
      req_in = 3'b000;
      tick();
      check_all("post.rel", 1'b0, 3'b010, 2'd1, 1'b1, 1'b0);
      ack_in = 1'b0;
      tick();
      check_all("post.done", 1'b0, 3'b000, 2'd0, 1'b0, 1'b0);

      // Final reset clears everything, including a sticky timeout.
      rst_n = 1'b0;
      tick();
      exp_to = 1'b0;
      check_all("end.rst", 1'b0, 3'b000, 2'd0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
